// File: rtl/mux_sequencial_param.sv
// rtl/mux_sequencial_param.sv - N-channel registered mux with manual select and timed auto scan
//
// Purpose:
//   Selects one of CANAIS packed W-bit channels onto a registered output.
//   MANUAL mode uses selector S directly. AUTO mode scans the channels in
//   ascending order, holding each one for DWELL enabled cycles. While a
//   channel is held, Y follows that channel's live data.
//
// Ports:
//   CLK      in   1             rising-edge clock
//   RST      in   1             synchronous reset, active-high, beats EN
//   D        in   CANAIS*WIDTH  packed channels, channel k = D[k*WIDTH +: WIDTH]
//   S        in   SEL_W         manual selector
//   MODO     in   1             0 = MANUAL, 1 = AUTO
//   EN       in   1             clock enable, low freezes Y/CANAL/cnt/state
//   MASCARA  in   CANAIS        (MASK_EN only) 1 = skip channel
//   Y        out  WIDTH         registered selected data
//   CANAL    out  SEL_W         index of the channel currently on Y
//   VALID    out  1             Y holds a legal channel this cycle
//   WRAP     out  1             one-cycle pulse when the auto scan wraps
//
// Build option:
//   MASK_EN  adds MASCARA and the masked-channel skip logic.

module mux_sequencial_param #(
  parameter int WIDTH  = 1,
  parameter int CANAIS = 4,
  parameter int SEL_W  = 2,
  parameter int DWELL  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [CANAIS*WIDTH-1:0] D,
  input  logic [SEL_W-1:0]        S,
  input  logic                    MODO,
  input  logic                    EN,
`ifdef MASK_EN
  input  logic [CANAIS-1:0]       MASCARA,
`endif
  output logic [WIDTH-1:0]        Y,
  output logic [SEL_W-1:0]        CANAL,
  output logic                    VALID,
  output logic                    WRAP
);

  localparam int CNT_W = $clog2(DWELL) + 1;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0] canal_q, canal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

  // Scan helpers: lowest usable channel, next usable channel above the
  // current one, and whether any channel is usable at all.
  int               canal_i;
  int               first_idx;
  int               above_idx;
  logic             above_found;
  logic             any_usable;
  logic             s_legal;

  // Variable channel lookup written as a compare loop so an out-of-range
  // index simply yields zero instead of reading past the bus.
  function automatic logic [WIDTH-1:0] chan_data(input logic [CANAIS*WIDTH-1:0] d_bus,
                                                 input int idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < CANAIS; k++) begin
      if (k == idx) r = d_bus[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  assign canal_i = int'(canal_q);

`ifdef MASK_EN
  function automatic logic chan_masked(input logic [CANAIS-1:0] msk, input int idx);
    logic r;
    r = 1'b1;
    for (int k = 0; k < CANAIS; k++) begin
      if (k == idx) r = msk[k];
    end
    return r;
  endfunction

  // Descending walk so the last hit recorded is the lowest qualifying index.
  always_comb begin
    first_idx   = 0;
    above_idx   = 0;
    above_found = 1'b0;
    any_usable  = 1'b0;
    for (int k = CANAIS - 1; k >= 0; k--) begin
      if (!MASCARA[k]) begin
        first_idx  = k;
        any_usable = 1'b1;
        if (k > canal_i) begin
          above_idx   = k;
          above_found = 1'b1;
        end
      end
    end
  end

  assign s_legal = (int'(S) < CANAIS) && !chan_masked(MASCARA, int'(S));
`else
  always_comb begin
    first_idx   = 0;
    any_usable  = 1'b1;
    above_found = (canal_i < CANAIS - 1);
    above_idx   = canal_i + 1;
  end

  assign s_legal = (int'(S) < CANAIS);
`endif

  // Next-state and output logic. VALID and WRAP default low so a frozen
  // cycle (EN=0) reports nothing while all other state holds.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    canal_d = canal_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;

    if (EN) begin
      if (!MODO) begin
        // MANUAL (also covers the edge that leaves AUTO).
        state_d = ST_MANUAL;
        canal_d = S;
        if (s_legal) begin
          y_d     = chan_data(D, int'(S));
          valid_d = 1'b1;
        end else begin
          y_d     = '0;
        end
      end else if (state_q == ST_MANUAL) begin
        // AUTO entry: the scan always restarts from the lowest usable channel.
        state_d = ST_AUTO;
        cnt_d   = '0;
        if (any_usable) begin
          canal_d = SEL_W'(first_idx);
          y_d     = chan_data(D, first_idx);
          valid_d = 1'b1;
        end
      end else if (any_usable) begin
        if (int'(cnt_q) == DWELL - 1) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          if (above_found) begin
            canal_d = SEL_W'(above_idx);
            y_d     = chan_data(D, above_idx);
          end else begin
            // No usable channel above the current one: wrap to the bottom.
            canal_d = SEL_W'(first_idx);
            y_d     = chan_data(D, first_idx);
            wrap_d  = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          y_d     = chan_data(D, canal_i);
          valid_d = 1'b1;
        end
      end
      // AUTO with every channel masked: CANAL/Y/cnt hold, VALID stays low.
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_MANUAL;
      y_q     <= '0;
      canal_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      canal_q <= canal_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Y     = y_q;
  assign CANAL = canal_q;
  assign VALID = valid_q;
  assign WRAP  = wrap_q;

endmodule

// File: tb/tb_mux_sequencial_param.sv
// tb/tb_mux_sequencial_param.sv - randomized self-checking bench for mux_sequencial_param
//
// Two instances share control inputs:
//   dut_a  WIDTH=1 CANAIS=4 SEL_W=2 DWELL=4
//   dut_b  WIDTH=4 CANAIS=3 SEL_W=2 DWELL=1 (illegal selector 3, non power-of-2 wrap)
// Expected outputs come from a model that counts enabled AUTO edges and
// derives the channel as (edges / DWELL) mod channel-count.

module tb_mux_sequencial_param;

  logic        clk = 1'b0;
  logic        rst, en, modo;
  logic [1:0]  s;
  logic [3:0]  d_a;
  logic [11:0] d_b;
  logic [3:0]  mask_a;
  logic [2:0]  mask_b;

  logic        y_a, valid_a, wrap_a;
  logic [1:0]  canal_a;
  logic [3:0]  y_b;
  logic        valid_b, wrap_b;
  logic [1:0]  canal_b;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b.
  bit m_auto[2];
  int m_k[2];
  int m_y[2];
  int m_canal[2];
  bit m_valid[2];
  bit m_wrap[2];

  always #5 clk = ~clk;

  mux_sequencial_param #(.WIDTH(1), .CANAIS(4), .SEL_W(2), .DWELL(4)) dut_a (
    .CLK(clk), .RST(rst), .D(d_a), .S(s), .MODO(modo), .EN(en),
`ifdef MASK_EN
    .MASCARA(mask_a),
`endif
    .Y(y_a), .CANAL(canal_a), .VALID(valid_a), .WRAP(wrap_a)
  );

  mux_sequencial_param #(.WIDTH(4), .CANAIS(3), .SEL_W(2), .DWELL(1)) dut_b (
    .CLK(clk), .RST(rst), .D(d_b), .S(s), .MODO(modo), .EN(en),
`ifdef MASK_EN
    .MASCARA(mask_b),
`endif
    .Y(y_b), .CANAL(canal_b), .VALID(valid_b), .WRAP(wrap_b)
  );

  function automatic logic [15:0] obs(input int id);
    if (id == 0) return {8'd0, 3'd0, y_a, canal_a, valid_a, wrap_a};
    return {8'd0, y_b, canal_b, valid_b, wrap_b};
  endfunction

  function automatic logic [15:0] expv(input int id);
    return {8'd0, 4'(m_y[id]), 2'(m_canal[id]), m_valid[id], m_wrap[id]};
  endfunction

  task automatic model_step();
    for (int id = 0; id < 2; id++) begin
      int ch[4];
      bit msk[4];
      int lst[4];
      int len, n, dw, slot, pos;
      n  = (id == 0) ? 4 : 3;
      dw = (id == 0) ? 4 : 1;
      for (int c = 0; c < 4; c++) begin
        if (id == 0) begin
          ch[c]  = int'(d_a[c]);
          msk[c] = mask_a[c];
        end else if (c < 3) begin
          ch[c]  = int'(d_b[c*4 +: 4]);
          msk[c] = mask_b[c];
        end else begin
          ch[c]  = 0;
          msk[c] = 1'b1;
        end
      end
      len = 0;
      for (int c = 0; c < n; c++) begin
        if (!msk[c]) begin
          lst[len] = c;
          len++;
        end
      end
      if (rst) begin
        m_auto[id] = 0; m_k[id] = 0; m_y[id] = 0; m_canal[id] = 0;
        m_valid[id] = 0; m_wrap[id] = 0;
      end else if (!en) begin
        m_valid[id] = 0; m_wrap[id] = 0;
      end else if (!modo) begin
        m_auto[id]  = 0;
        m_wrap[id]  = 0;
        m_canal[id] = int'(s);
        if (int'(s) < n && !msk[s]) begin
          m_y[id] = ch[s]; m_valid[id] = 1;
        end else begin
          m_y[id] = 0; m_valid[id] = 0;
        end
      end else begin
        if (!m_auto[id]) begin
          m_auto[id] = 1; m_k[id] = 0;
        end else begin
          m_k[id]++;
        end
        if (len == 0) begin
          m_valid[id] = 0; m_wrap[id] = 0;
        end else begin
          slot = m_k[id] / dw;
          pos  = slot % len;
          m_canal[id] = lst[pos];
          m_y[id]     = ch[lst[pos]];
          m_valid[id] = 1;
          m_wrap[id]  = (m_k[id] % dw == 0) && (slot > 0) && (pos == 0);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; modo = 1'b0; s = 2'($urandom);
    for (int c = 0; c < 2; c++) begin
      d_a = 4'($urandom); d_b = 12'($urandom);
      tick();
      for (int id = 0; id < 2; id++) begin
        n_vec++;
        if (obs(id) !== 16'h0000) begin
          n_err++;
          $display("FAIL reset dut%0d cyc%0d: got %h expected %h", id, c, obs(id), 16'h0000);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_manual();
    d_a = 4'b1010; d_b = 12'h5c3; modo = 1'b0; en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s = 2'(k);
      tick();
      for (int id = 0; id < 2; id++) begin
        n_vec++;
        if (obs(id) !== expv(id)) begin
          n_err++;
          $display("FAIL manual dut%0d s=%0d: got %h expected %h", id, k, obs(id), expv(id));
        end
      end
    end
    for (int c = 0; c < 20; c++) begin
      s = 2'($urandom); d_a = 4'($urandom); d_b = 12'($urandom);
      tick();
      for (int id = 0; id < 2; id++) begin
        n_vec++;
        if (obs(id) !== expv(id)) begin
          n_err++;
          $display("FAIL manual_rand dut%0d cyc%0d: got %h expected %h", id, c, obs(id), expv(id));
        end
      end
    end
  endtask

  task automatic test_illegal_sel();
    modo = 1'b0; en = 1'b1; s = 2'd3;
    for (int c = 0; c < 3; c++) begin
      d_b = 12'($urandom) | 12'hfff;
      tick();
      n_vec++;
      if ({y_b, valid_b, canal_b} !== {4'h0, 1'b0, 2'd3}) begin
        n_err++;
        $display("FAIL illegal_sel cyc%0d: got y=%h valid=%b canal=%0d expected y=0 valid=0 canal=3",
                 c, y_b, valid_b, canal_b);
      end
    end
  endtask

  task automatic test_auto_scan();
    modo = 1'b0; en = 1'b1; s = 2'd2;
    tick();
    modo = 1'b1;
    for (int c = 0; c < 40; c++) begin
      d_a = 4'($urandom); d_b = 12'($urandom); s = 2'($urandom);
      tick();
      for (int id = 0; id < 2; id++) begin
        n_vec++;
        if (obs(id) !== expv(id)) begin
          n_err++;
          $display("FAIL auto_scan dut%0d cyc%0d: got %h expected %h", id, c, obs(id), expv(id));
        end
      end
    end
  endtask

  task automatic test_freeze_resume();
    modo = 1'b0; en = 1'b1;
    tick();
    modo = 1'b1;
    for (int c = 0; c < 7; c++) begin
      d_a = 4'($urandom); d_b = 12'($urandom);
      tick();
    end
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      d_a = 4'($urandom); d_b = 12'($urandom);
      tick();
      for (int id = 0; id < 2; id++) begin
        n_vec++;
        if (obs(id) !== expv(id)) begin
          n_err++;
          $display("FAIL freeze dut%0d cyc%0d: got %h expected %h", id, c, obs(id), expv(id));
        end
      end
    end
    en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      d_a = 4'($urandom); d_b = 12'($urandom);
      tick();
      for (int id = 0; id < 2; id++) begin
        n_vec++;
        if (obs(id) !== expv(id)) begin
          n_err++;
          $display("FAIL resume dut%0d cyc%0d: got %h expected %h", id, c, obs(id), expv(id));
        end
      end
    end
    rst = 1'b1;
    tick();
    for (int id = 0; id < 2; id++) begin
      n_vec++;
      if (obs(id) !== 16'h0000) begin
        n_err++;
        $display("FAIL midscan_reset dut%0d: got %h expected %h", id, obs(id), 16'h0000);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    modo = 1'b0;
    for (int c = 0; c < 300; c++) begin
      rst  = ($urandom_range(0, 39) == 0);
      en   = ($urandom_range(0, 4) != 0);
      modo = ($urandom_range(0, 11) == 0) ? ~modo : modo;
      s    = 2'($urandom);
      d_a  = 4'($urandom);
      d_b  = 12'($urandom);
      tick();
      for (int id = 0; id < 2; id++) begin
        n_vec++;
        if (obs(id) !== expv(id)) begin
          n_err++;
          $display("FAIL random dut%0d cyc%0d: got %h expected %h", id, c, obs(id), expv(id));
        end
      end
    end
    rst = 1'b0; en = 1'b1; modo = 1'b0;
  endtask

`ifdef MASK_EN
  task automatic test_mask();
    mask_a = 4'b0101; mask_b = 3'b010; modo = 1'b0; en = 1'b1; rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s = 2'(k); d_a = 4'($urandom); d_b = 12'($urandom);
      tick();
      for (int id = 0; id < 2; id++) begin
        n_vec++;
        if (obs(id) !== expv(id)) begin
          n_err++;
          $display("FAIL mask_manual dut%0d s=%0d: got %h expected %h", id, k, obs(id), expv(id));
        end
      end
    end
    modo = 1'b1;
    for (int c = 0; c < 24; c++) begin
      d_a = 4'($urandom); d_b = 12'($urandom);
      tick();
      for (int id = 0; id < 2; id++) begin
        n_vec++;
        if (obs(id) !== expv(id)) begin
          n_err++;
          $display("FAIL mask_auto dut%0d cyc%0d: got %h expected %h", id, c, obs(id), expv(id));
        end
      end
    end
    mask_a = 4'b1111; mask_b = 3'b111;
    for (int c = 0; c < 4; c++) begin
      d_a = 4'($urandom); d_b = 12'($urandom);
      tick();
      for (int id = 0; id < 2; id++) begin
        n_vec++;
        if (obs(id) !== expv(id)) begin
          n_err++;
          $display("FAIL mask_all dut%0d cyc%0d: got %h expected %h", id, c, obs(id), expv(id));
        end
      end
    end
    modo = 1'b0; mask_a = '0; mask_b = '0;
    tick();
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b1; modo = 1'b0; s = '0;
    d_a = '0; d_b = '0; mask_a = '0; mask_b = '0;
    test_reset();
    test_manual();
    test_illegal_sel();
    test_auto_scan();
    test_freeze_resume();
`ifdef MASK_EN
    test_mask();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
